// File: rtl/cdc_pkg.sv
// Shared definitions for the clock-domain-crossing receive blocks.
// Holds the receive handshake FSM states and the transfer counter width.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    ACK   = 2'd2
  } hs_rx_state_t;

  localparam int XFER_CNT_W = 16;

endpackage : cdc_pkg

// File: rtl/hs_rx_ctrl.sv
// Receive side of a 4-phase req/ack crossing: captures the sender's bus once per
// request, offers it downstream with valid/ready, then acknowledges to the sender.
module hs_rx_ctrl
  import cdc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_sync,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  ack,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [XFER_CNT_W-1:0] xfer_cnt,
  output logic                  proto_err
);

  hs_rx_state_t          r_state;
  hs_rx_state_t          w_state_next;
  logic                  w_capture;
  logic                  w_deliver;
  logic                  w_req_drop;
  logic                  r_ack;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [XFER_CNT_W-1:0] r_xfer_cnt;
  logic                  r_proto_err;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_deliver    = 1'b0;
    w_req_drop   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_sync) begin
          w_capture    = 1'b1;
          w_state_next = VALID;
        end
      end
      VALID: begin
        // Sender released its request before we acknowledged: flag it, keep the word.
        w_req_drop = !req_sync;
        if (out_ready) begin
          w_deliver    = 1'b1;
          w_state_next = ACK;
        end
      end
      ACK: begin
        if (!req_sync) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ack and out_valid come straight from flops so the crossing sees no glitches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ack       <= 1'b0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_xfer_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ack       <= (w_state_next == ACK);
      r_out_valid <= (w_state_next == VALID);
      if (w_capture) begin
        r_data <= in_data;
      end
      if (w_deliver) begin
        r_xfer_cnt <= r_xfer_cnt + XFER_CNT_W'(1);
      end
      if (w_req_drop) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign ack       = r_ack;
  assign out_valid = r_out_valid;
  assign out_data  = r_data;
  assign xfer_cnt  = r_xfer_cnt;
  assign proto_err = r_proto_err;

endmodule : hs_rx_ctrl

// File: tb/tb_hs_rx_ctrl.sv
// Randomized transaction-level bench for hs_rx_ctrl: a sender/receiver model
// predicts data, handshake timing, the transfer count and the error flag.
module tb_hs_rx_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_sync;
  logic [DW-1:0] in_data;
  logic          ack;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [15:0]   xfer_cnt;
  logic          proto_err;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [15:0]   exp_cnt;
  logic          exp_perr;

  hs_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_sync  (req_sync),
    .in_data   (in_data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One sender transaction: request, optional downstream stall, optional early
  // request drop (protocol violation), optional request hold after ack.
  task automatic send_word(input logic [DW-1:0] d, input int rdy_dly,
                           input bit early_drop, input int hold);
    req_sync  = 1'b1;
    in_data   = d;
    out_ready = 1'($urandom_range(0, 1));
    tick();
    chk("cap_valid", 32'(out_valid), 32'd1);
    chk("cap_data", 32'(out_data), 32'(d));
    chk("cap_ack", 32'(ack), 32'd0);
    in_data   = DW'($urandom);
    out_ready = 1'b0;
    if (early_drop) begin
      req_sync = 1'b0;
      exp_perr = 1'b1;
    end
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(d));
      chk("stall_ack", 32'(ack), 32'd0);
      chk("stall_perr", 32'(proto_err), 32'(exp_perr));
    end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    chk("ack_rise", 32'(ack), 32'd1);
    chk("ack_valid", 32'(out_valid), 32'd0);
    chk("ack_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    chk("ack_perr", 32'(proto_err), 32'(exp_perr));
    out_ready = 1'($urandom_range(0, 1));
    if (!early_drop) begin
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_ack", 32'(ack), 32'd1);
        chk("hold_valid", 32'(out_valid), 32'd0);
        chk("hold_cnt", 32'(xfer_cnt), 32'(exp_cnt));
      end
      req_sync = 1'b0;
    end
    tick();
    chk("ack_fall", 32'(ack), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    chk("idle_data", 32'(out_data), 32'(d));
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      chk("gap_valid", 32'(out_valid), 32'd0);
      chk("gap_ack", 32'(ack), 32'd0);
    end
    $display("xfer data=%02h dly=%0d drop=%0d hold=%0d cnt=%0d perr=%0d",
             d, rdy_dly, early_drop, hold, xfer_cnt, proto_err);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_cnt"}, 32'(xfer_cnt), 32'd0);
    chk({tag, "_perr"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_sync  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    exp_cnt   = '0;
    exp_perr  = 1'b0;
    tick();
    tick();
    chk_reset_state("rst");
    rst_n = 1'b1;
    tick();

    send_word(8'hA5, 0, 1'b0, 0);
    send_word(DW'($urandom), 10, 1'b0, 0);
    send_word(DW'($urandom), 1, 1'b0, 20);
    for (int t = 0; t < 40; t++) begin
      send_word(DW'($urandom), int'($urandom_range(0, 4)), 1'b0, int'($urandom_range(0, 3)));
    end
    send_word(DW'($urandom), 3, 1'b1, 0);
    for (int t = 0; t < 10; t++) begin
      send_word(DW'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)));
    end

    // Counter wrap: preset to all-ones while idle, then complete one transfer.
    @(negedge clk);
    force dut.r_xfer_cnt = 16'hFFFF;
    tick();
    release dut.r_xfer_cnt;
    exp_cnt = 16'hFFFF;
    tick();
    chk("preset_cnt", 32'(xfer_cnt), 32'h0000FFFF);
    send_word(DW'($urandom), 0, 1'b0, 0);
    chk("wrap_cnt", 32'(xfer_cnt), 32'd0);

    // Reset while in ACK, request still high: fresh capture on release.
    req_sync  = 1'b1;
    in_data   = 8'h3C;
    out_ready = 1'b1;
    tick();
    tick();
    chk("pre_rst_ack", 32'(ack), 32'd1);
    rst_n = 1'b0;
    tick();
    exp_cnt  = '0;
    exp_perr = 1'b0;
    chk_reset_state("rst_ack");
    rst_n   = 1'b1;
    in_data = 8'hC3;
    tick();
    chk("rel_valid", 32'(out_valid), 32'd1);
    chk("rel_data", 32'(out_data), 32'hC3);
    tick();
    exp_cnt++;
    chk("rel_ack", 32'(ack), 32'd1);
    chk("rel_cnt", 32'(xfer_cnt), 32'(exp_cnt));
    req_sync = 1'b0;
    tick();
    chk("rel_ack_fall", 32'(ack), 32'd0);

    // Reset on the same edge as a delivery in VALID: word abandoned, no count.
    req_sync  = 1'b1;
    in_data   = 8'h5A;
    out_ready = 1'b0;
    tick();
    chk("v_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    req_sync  = 1'b0;
    rst_n     = 1'b0;
    tick();
    exp_cnt = '0;
    chk_reset_state("rst_valid");
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_ack", 32'(ack), 32'd0);
    chk("post_rst_cnt", 32'(xfer_cnt), 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_hs_rx_ctrl
